// File: rtl/vga_logo_scanner.sv
// rtl/vga_logo_scanner.sv - VGA raster timing, logo offset animation and colour/sync output stage
module vga_logo_scanner #(
  parameter int         H_VISIBLE = 800,
  parameter int         H_FP      = 56,
  parameter int         H_SYNC    = 120,
  parameter int         H_BP      = 64,
  parameter int         V_VISIBLE = 600,
  parameter int         V_FP      = 37,
  parameter int         V_SYNC    = 6,
  parameter int         V_BP      = 23,
  parameter logic       SYNC_POL  = 1'b1,
  parameter int         DELT_STEP = 10,
  parameter int         DELT_MAX  = 250,
  parameter logic [8:0] FG_COLOR  = 9'h1FF,
  parameter logic [8:0] BG_COLOR  = 9'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        hit,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic [10:0] delt,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic [8:0]  rgb
);

  localparam logic [10:0] H_LAST   = 11'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] V_LAST   = 11'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [10:0] STEP     = 11'(DELT_STEP);
  localparam logic [10:0] DMAX     = 11'(DELT_MAX);
  localparam logic [10:0] UP_LIMIT = 11'(DELT_MAX - DELT_STEP);

  typedef enum logic {UP, DOWN} dir_t;

  dir_t        state;
  dir_t        state_next;
  logic [10:0] delt_next;
  logic        line_end;
  logic        frame_wrap;
  logic        vis;
  logic        hs_act;
  logic        vs_act;

  assign line_end   = (x == H_LAST);
  assign frame_wrap = line_end && (y == V_LAST);

  // Stage 0: pixel counters, x per clock and y per completed line
  always_ff @(posedge clk) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (line_end) begin
      x <= '0;
      y <= (y == V_LAST) ? 11'd0 : y + 11'd1;
    end else begin
      x <= x + 11'd1;
    end
  end

  // Animation state register; delt only moves on the frame-wrap edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= UP;
      delt  <= '0;
    end else begin
      state <= state_next;
      delt  <= delt_next;
    end
  end

  // Bounce logic: saturate at the ends and reverse direction there
  always_comb begin
    state_next = state;
    delt_next  = delt;
    if (frame_wrap && enable) begin
      case (state)
        UP: begin
          if (delt >= UP_LIMIT) begin
            delt_next  = DMAX;
            state_next = DOWN;
          end else begin
            delt_next = delt + STEP;
          end
        end
        DOWN: begin
          if (delt <= STEP) begin
            delt_next  = '0;
            state_next = UP;
          end else begin
            delt_next = delt - STEP;
          end
        end
        default: begin
          state_next = UP;
        end
      endcase
    end
  end

  assign vis    = (x < H_VIS) && (y < V_VIS);
  assign hs_act = (x >= HS_START) && (x < HS_END);
  assign vs_act = (y >= VS_START) && (y < VS_END);

  // Stage 1: register colour and syncs together so they stay mutually aligned
  always_ff @(posedge clk) begin
    if (rst) begin
      video_on <= 1'b0;
      rgb      <= '0;
      hsync    <= ~SYNC_POL;
      vsync    <= ~SYNC_POL;
    end else begin
      video_on <= vis;
      rgb      <= vis ? (hit ? FG_COLOR : BG_COLOR) : 9'h000;
      hsync    <= hs_act ? SYNC_POL : ~SYNC_POL;
      vsync    <= vs_act ? SYNC_POL : ~SYNC_POL;
    end
  end

endmodule

// File: tb/tb_vga_logo_scanner.sv
// tb/tb_vga_logo_scanner.sv - scoreboard bench for vga_logo_scanner on a shrunken raster
module tb_vga_logo_scanner;

  localparam int HV = 8, HFP = 2, HS = 3, HBP = 2, HT = HV + HFP + HS + HBP;
  localparam int VV = 6, VFP = 1, VS = 2, VBP = 1, VT = VV + VFP + VS + VBP;
  localparam int HITX = 5, HITY = 3;
  localparam int BUDGET = 20000;

  typedef struct packed {
    logic       rs;
    logic       v;
    logic       hs;
    logic       vs;
    logic [8:0] rgb;
    int         px;
    int         py;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        hit;
  logic [10:0] x;
  logic [10:0] y;
  logic [10:0] delt;
  logic        hsync;
  logic        vsync;
  logic        video_on;
  logic [8:0]  rgb;
  logic        hit_mode;

  int tests = 0;
  int fails = 0;

  exp_t q[$];
  int   mx, my, md;
  int   frames, paused;
  bit   mon_on = 0;
  bit   tri_pending = 0;
  int   von_cnt, hs_cnt, vs_cnt, fg_cnt;

  vga_logo_scanner #(
    .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(1'b1), .DELT_STEP(10), .DELT_MAX(250),
    .FG_COLOR(9'h1FF), .BG_COLOR(9'h000)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .hit(hit),
    .x(x), .y(y), .delt(delt),
    .hsync(hsync), .vsync(vsync), .video_on(video_on), .rgb(rgb)
  );

  // painter stub: single pixel or whole screen
  assign hit = hit_mode ? 1'b1 : ((x == 11'(HITX)) && (y == 11'(HITY)));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // expected delt after n enabled frame wraps: triangle wave 0..250..0
  function automatic int tri_val(input int n);
    int m;
    m = n % 50;
    if (m <= 25) return 10 * m;
    return 500 - 10 * m;
  endfunction

  function automatic void clear_counts();
    von_cnt = 0; hs_cnt = 0; vs_cnt = 0; fg_cnt = 0;
  endfunction

  // monitor + scoreboard: compare, then predict the next cycle
  always @(negedge clk) begin
    exp_t e;
    exp_t n;
    bit   hv;
    if (mon_on) begin
      chk("x", int'(x), mx);
      chk("y", int'(y), my);
      chk("delt", int'(delt), md);
      if (tri_pending) begin
        chk("bounce_delt", int'(delt), tri_val(frames));
        tri_pending = 0;
      end
      if (q.size() == 0) begin
        chk("queue_nonempty", 0, 1);
      end else begin
        e = q.pop_front();
        chk("video_on", int'(video_on), int'(e.v));
        chk("hsync", int'(hsync), int'(e.hs));
        chk("vsync", int'(vsync), int'(e.vs));
        chk("rgb", int'(rgb), int'(e.rgb));
        if (!e.rs) begin
          von_cnt += int'(video_on);
          hs_cnt  += int'(hsync);
          vs_cnt  += int'(vsync);
          fg_cnt  += int'(rgb == 9'h1FF);
          if (e.px == HT - 1 && e.py == VT - 1) begin
            chk("frame_video_on_cycles", von_cnt, HV * VV);
            chk("frame_hsync_cycles", hs_cnt, HS * VT);
            chk("frame_vsync_cycles", vs_cnt, VS * HT);
            chk("frame_fg_pixels", fg_cnt, hit_mode ? HV * VV : 1);
            clear_counts();
          end
        end
      end
    end
    if (rst) begin
      q.delete();
      n = '0;
      n.rs = 1'b1;
      q.push_back(n);
      mx = 0; my = 0; md = 0;
      frames = 0; paused = 0;
      tri_pending = 0;
      clear_counts();
      mon_on = 1;
    end else if (mon_on) begin
      hv = hit_mode ? 1'b1 : (mx == HITX && my == HITY);
      n = '0;
      n.v   = (mx < HV) && (my < VV);
      n.hs  = (mx >= HV + HFP) && (mx < HV + HFP + HS);
      n.vs  = (my >= VV + VFP) && (my < VV + VFP + VS);
      n.rgb = (n.v && hv) ? 9'h1FF : 9'h000;
      n.px  = mx;
      n.py  = my;
      q.push_back(n);
      if (mx == HT - 1 && my == VT - 1) begin
        if (enable) frames++;
        else paused++;
        md = tri_val(frames);
        tri_pending = 1;
      end
      if (mx == HT - 1) begin
        mx = 0;
        my = (my == VT - 1) ? 0 : my + 1;
      end else begin
        mx = mx + 1;
      end
    end
  end

  task automatic wait_frames(input int n);
    int c = 0;
    while (frames < n && c < BUDGET) begin
      @(negedge clk);
      c++;
    end
    chk("frames_reached", frames, n);
  endtask

  task automatic wait_paused(input int n);
    int c = 0;
    while (paused < n && c < BUDGET) begin
      @(negedge clk);
      c++;
    end
    chk("paused_wraps_reached", paused, n);
  endtask

  initial begin
    int c;
    bit found;
    rst = 1'b1;
    enable = 1'b1;
    hit_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_x", int'(x), 0);
    chk("reset_delt", int'(delt), 0);
    chk("reset_rgb", int'(rgb), 0);
    chk("reset_hsync", int'(hsync), 0);
    chk("reset_vsync", int'(vsync), 0);

    // mid-frame reset once delt has moved
    wait_frames(2);
    chk("pre_reset_delt", int'(delt), 20);
    found = 0;
    c = 0;
    while (!found && c < BUDGET) begin
      @(posedge clk);
      #1;
      c++;
      if (mx == HITX - 1 && my == HITY) found = 1;
    end
    chk("found_mid_frame_pixel", int'(found), 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("midrst_x", int'(x), 0);
    chk("midrst_y", int'(y), 0);
    chk("midrst_delt", int'(delt), 0);
    chk("midrst_rgb", int'(rgb), 0);
    chk("midrst_hsync", int'(hsync), 0);
    chk("midrst_vsync", int'(vsync), 0);
    chk("midrst_video_on", int'(video_on), 0);

    // full bounce: up to 250, down to 0, back up to 10
    wait_frames(25);
    chk("delt_at_top", int'(delt), 250);
    wait_frames(26);
    chk("delt_first_down", int'(delt), 240);
    wait_frames(50);
    chk("delt_back_to_zero", int'(delt), 0);
    wait_frames(51);
    chk("delt_up_again", int'(delt), 10);

    // whole-screen hit, then pause at 120 across two wraps
    @(posedge clk);
    #1;
    rst = 1'b1;
    hit_mode = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    wait_frames(12);
    chk("delt_before_pause", int'(delt), 120);
    @(posedge clk);
    #1 enable = 1'b0;
    wait_paused(2);
    chk("delt_paused", int'(delt), 120);
    @(posedge clk);
    #1 enable = 1'b1;
    wait_frames(13);
    chk("delt_resumed", int'(delt), 130);
    repeat (HT * 2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
